pocket_player_binder: RTL
=========================

Name: pocket_player_binder

Overview:
- Frame-synchronous controller-to-player scheduler.
- Snapshots the four APF controller inputs (key/joy/trig) once per video frame. Arbitrates "press START to join" requests into NUM_PLAYERS player slots and publishes stable per-player controller state to the core.
- Sits between the APF controller input registers and the core's input logic. The core sees inputs change only at frame boundaries, with a deterministic player assignment.

Parameters:
- NUM_PLAYERS, 4, number of player slots (1..4).
- DROP_FRAMES, 60, consecutive frames a bound controller must report controller_none before its slot is freed (1..255).

Ports:
- clk_74a  input  1  system clock; all logic in this domain.
- reset_n  input  1  asynchronous active-low reset.
- frame_strobe_i  input  1  single-cycle pulse at frame start (vsync). Pulses are at least 16 cycles apart.
- unbind_all_i  input  1  single-cycle request to free all slots.
- cont_key_i  input  4x32  pocket::key_t per physical controller 0..3.
- cont_joy_i  input  4x32  pocket::joy_t per controller.
- cont_trig_i  input  4x16  pocket::trig_t per controller.
- player_key_o  output  NUM_PLAYERSx32  key_t routed to each player.
- player_joy_o  output  NUM_PLAYERSx32  joy_t per player.
- player_trig_o  output  NUM_PLAYERSx16  trig_t per player.
- player_bound_o  output  NUM_PLAYERS  slot occupied.
- player_src_o  output  NUM_PLAYERSx2  physical controller index bound to the slot.
- join_pulse_o  output  1  one-cycle pulse in PUBLISH when at least one join was granted that frame.
- overrun_o  output  1  sticky: frame_strobe_i arrived while the FSM was not IDLE. Cleared only by reset.

Behaviour:
- Reset values:
  - All slots free. player_bound_o=0, player_src_o=0.
  - player_key_o=0, player_joy_o=32'h80808080 (centred), player_trig_o=0.
  - join_pulse_o=0, overrun_o=0.
  - Round-robin pointer rr=0, drop counters=0, previous-START history=0.
- FSM states: IDLE -> CAPTURE -> ARB0 -> ARB1 -> ARB2 -> ARB3 -> PUBLISH -> IDLE.
- IDLE:
  - Waits for frame_strobe_i.
  - unbind_all_i seen in any state sets a pending-clear flag.
- CAPTURE (1 cycle): registers all cont_*_i into a snapshot.
  - present[c] = (controller_type != controller_none).
  - req[c] = present[c] & face_start & ~prev_start[c] & ~bound_by_any_slot(c).
  - prev_start[c] is updated from the snapshot.
- ARBn (1 cycle each): examines controller c=(rr+n) mod 4.
  - If req[c] and a free slot exists: bind c to the lowest-index free slot, record the grant.
  - If no slot is free, the request is dropped; the player must re-press START.
  - A controller is granted at most once per frame.
- PUBLISH (1 cycle), in order:
  - (a) If pending-clear: free all slots, clear the pending flag, discard this frame's grants. The drop counters still update.
  - (b) For each bound slot whose source is not present: increment its drop counter, saturating at 255. When the counter reaches DROP_FRAMES the slot is freed and the counter zeroed. A present source zeroes its counter.
  - (c) Output registers load from the snapshot for bound slots and from reset constants for free slots.
  - (d) join_pulse_o=1 if any grant survived.
  - (e) rr = (last granted controller + 1) mod 4; unchanged if no grant.
- Latency: player_*_o change exactly 7 cycles after the frame_strobe_i cycle. Outputs are otherwise held constant.
- A frame_strobe_i outside IDLE is ignored and sets overrun_o.
- A newly joined player's outputs carry the same snapshot that contained the START press.
- A controller freed by a drop may rejoin only via a new START rising edge in a later frame.
- Reset asserted mid-sequence returns everything to reset values immediately. No partial bind persists.

Test Plan:
1. Reset, then controller 1 type=docked_analogue with START rising on frame 1 -> at strobe+7: player_bound_o=4'b0001, player_src_o[0]=1, join_pulse_o=1 for one cycle. player_key_o[0] equals the frame-1 snapshot.
2. Controllers 0 and 2 press START in the same frame, rr=0 -> slot0<-ctrl0, slot1<-ctrl2, rr=3. Next frame ctrl3 presses START -> slot2<-ctrl3.
3. Bound ctrl1 reports controller_none with DROP_FRAMES=3 -> slot still bound after frames 1-2, freed at PUBLISH of frame 3. The free slot outputs key=0, joy=32'h80808080.
4. NUM_PLAYERS=2, both slots bound, ctrl3 presses START -> no grant, join_pulse_o stays 0. ctrl3 holding START on the next frame produces no join (no new edge).
5. unbind_all_i in the same frame as a ctrl0 join -> all slots free, join_pulse_o=0.
6. Second frame_strobe_i 3 cycles after the first -> overrun_o=1 and sticky, and the first frame publishes normally. Asserting reset_n low during ARB2 -> all outputs return to reset values.

Source files
------------

// File: rtl/pocket_player_binder.sv
// Frame-synchronous controller-to-player binder.
// Once per video frame, takes a snapshot of the four controller inputs. It
// arbitrates "press START to join" requests into NUM_PLAYERS slots and then
// publishes stable per-player controller state. The core therefore sees
// inputs change only at frame boundaries.
//
// Ports:
//   clk_74a, reset_n          clock, async active-low reset
//   frame_strobe_i            one-cycle frame start pulse
//   unbind_all_i              one-cycle request to free every slot
//   cont_key/joy/trig_i       raw per-controller words (4 controllers)
//   player_key/joy/trig_o     per-slot published controller words
//   player_bound_o/src_o      slot occupancy and bound controller index
//   join_pulse_o              one-cycle pulse when a join was committed
//   overrun_o                 sticky: strobe arrived mid-sequence
module pocket_player_binder #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned DROP_FRAMES = 60
) (
  input  logic                         clk_74a,
  input  logic                         reset_n,
  input  logic                         frame_strobe_i,
  input  logic                         unbind_all_i,
  input  logic [3:0][31:0]             cont_key_i,
  input  logic [3:0][31:0]             cont_joy_i,
  input  logic [3:0][15:0]             cont_trig_i,
  output logic [NUM_PLAYERS-1:0][31:0] player_key_o,
  output logic [NUM_PLAYERS-1:0][31:0] player_joy_o,
  output logic [NUM_PLAYERS-1:0][15:0] player_trig_o,
  output logic [NUM_PLAYERS-1:0]       player_bound_o,
  output logic [NUM_PLAYERS-1:0][1:0]  player_src_o,
  output logic                         join_pulse_o,
  output logic                         overrun_o
);

  localparam logic [31:0] JoyCentre = 32'h8080_8080;
  localparam logic [7:0]  DropLimit = 8'(DROP_FRAMES);
  localparam logic [3:0]  TypeNone  = 4'd0;
  localparam int unsigned StartBit  = 15;

  typedef enum logic [2:0] {
    StIdle, StCapture, StArb0, StArb1, StArb2, StArb3, StPublish
  } state_e;

  state_e                         state_q, state_d;
  logic [3:0][31:0]               snap_key_q, snap_key_d, snap_joy_q, snap_joy_d;
  logic [3:0][15:0]               snap_trig_q, snap_trig_d;
  logic [3:0]                     present_q, present_d, req_q, req_d;
  logic [3:0]                     prev_start_q, prev_start_d;
  // Committed binding (drives the outputs) and the working copy used by arbitration.
  logic [NUM_PLAYERS-1:0]         bound_q, bound_d, bound_t_q, bound_t_d;
  logic [NUM_PLAYERS-1:0][1:0]    src_q, src_d, src_t_q, src_t_d;
  logic [NUM_PLAYERS-1:0][7:0]    cnt_q, cnt_d;
  logic [NUM_PLAYERS-1:0][31:0]   key_q, key_d, joy_q, joy_d;
  logic [NUM_PLAYERS-1:0][15:0]   trig_q, trig_d;
  logic                           grant_any_q, grant_any_d;
  logic [1:0]                     last_grant_q, last_grant_d, rr_q, rr_d;
  logic                           clr_pend_q, clr_pend_d;
  logic                           join_q, join_d, overrun_q, overrun_d;

  logic [1:0] arb_n, arb_c;
  logic       pres, taken, done, bnd;
  logic [1:0] src;
  logic [7:0] cnt;

  always_comb begin
    arb_n = 2'd0;
    unique case (state_q)
      StArb1:  arb_n = 2'd1;
      StArb2:  arb_n = 2'd2;
      StArb3:  arb_n = 2'd3;
      default: arb_n = 2'd0;
    endcase
    arb_c = rr_q + arb_n;
  end

  always_comb begin
    state_d      = state_q;
    snap_key_d   = snap_key_q;
    snap_joy_d   = snap_joy_q;
    snap_trig_d  = snap_trig_q;
    present_d    = present_q;
    req_d        = req_q;
    prev_start_d = prev_start_q;
    bound_d      = bound_q;
    src_d        = src_q;
    bound_t_d    = bound_t_q;
    src_t_d      = src_t_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    joy_d        = joy_q;
    trig_d       = trig_q;
    grant_any_d  = grant_any_q;
    last_grant_d = last_grant_q;
    rr_d         = rr_q;
    clr_pend_d   = clr_pend_q;
    join_d       = 1'b0;
    overrun_d    = overrun_q;
    pres         = 1'b0;
    taken        = 1'b0;
    done         = 1'b0;
    bnd          = 1'b0;
    src          = 2'd0;
    cnt          = 8'd0;

    if (frame_strobe_i && state_q != StIdle) overrun_d = 1'b1;

    unique case (state_q)
      StIdle: if (frame_strobe_i) state_d = StCapture;
      StCapture: begin
        snap_key_d  = cont_key_i;
        snap_joy_d  = cont_joy_i;
        snap_trig_d = cont_trig_i;
        for (int c = 0; c < 4; c++) begin
          pres  = cont_key_i[c][31:28] != TypeNone;
          taken = 1'b0;
          for (int s = 0; s < NUM_PLAYERS; s++) begin
            if (bound_q[s] && src_q[s] == 2'(c)) taken = 1'b1;
          end
          present_d[c]    = pres;
          req_d[c]        = pres & cont_key_i[c][StartBit] & ~prev_start_q[c] & ~taken;
          prev_start_d[c] = pres & cont_key_i[c][StartBit];
        end
        bound_t_d    = bound_q;
        src_t_d      = src_q;
        grant_any_d  = 1'b0;
        last_grant_d = 2'd0;
        state_d      = StArb0;
      end
      StArb0, StArb1, StArb2, StArb3: begin
        // Lowest free slot wins; with no free slot the request is simply lost.
        done = 1'b0;
        for (int s = 0; s < NUM_PLAYERS; s++) begin
          if (req_q[arb_c] && !bound_t_q[s] && !done) begin
            bound_t_d[s] = 1'b1;
            src_t_d[s]   = arb_c;
            grant_any_d  = 1'b1;
            last_grant_d = arb_c;
            done         = 1'b1;
          end
        end
        unique case (state_q)
          StArb0:  state_d = StArb1;
          StArb1:  state_d = StArb2;
          StArb2:  state_d = StArb3;
          default: state_d = StPublish;
        endcase
      end
      StPublish: begin
        for (int s = 0; s < NUM_PLAYERS; s++) begin
          bnd = bound_t_q[s];
          src = src_t_q[s];
          cnt = cnt_q[s];
          if (bnd && !present_q[src]) begin
            if (cnt != 8'hFF) cnt = cnt + 8'd1;
            if (cnt >= DropLimit) begin
              bnd = 1'b0;
              cnt = 8'd0;
            end
          end else begin
            cnt = 8'd0;
          end
          // Counters advance even when a pending clear frees the slot.
          if (clr_pend_q) bnd = 1'b0;
          cnt_d[s]   = cnt;
          bound_d[s] = bnd;
          src_d[s]   = bnd ? src : 2'd0;
          key_d[s]   = bnd ? snap_key_q[src] : 32'd0;
          joy_d[s]   = bnd ? snap_joy_q[src] : JoyCentre;
          trig_d[s]  = bnd ? snap_trig_q[src] : 16'd0;
        end
        if (grant_any_q && !clr_pend_q) begin
          join_d = 1'b1;
          rr_d   = last_grant_q + 2'd1;
        end
        clr_pend_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // After the case so a request landing in PUBLISH carries into the next frame.
    if (unbind_all_i) clr_pend_d = 1'b1;
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      snap_key_q   <= '0;
      snap_joy_q   <= '0;
      snap_trig_q  <= '0;
      present_q    <= '0;
      req_q        <= '0;
      prev_start_q <= '0;
      bound_q      <= '0;
      src_q        <= '0;
      bound_t_q    <= '0;
      src_t_q      <= '0;
      cnt_q        <= '0;
      key_q        <= '0;
      joy_q        <= {NUM_PLAYERS{JoyCentre}};
      trig_q       <= '0;
      grant_any_q  <= 1'b0;
      last_grant_q <= 2'd0;
      rr_q         <= 2'd0;
      clr_pend_q   <= 1'b0;
      join_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_key_q   <= snap_key_d;
      snap_joy_q   <= snap_joy_d;
      snap_trig_q  <= snap_trig_d;
      present_q    <= present_d;
      req_q        <= req_d;
      prev_start_q <= prev_start_d;
      bound_q      <= bound_d;
      src_q        <= src_d;
      bound_t_q    <= bound_t_d;
      src_t_q      <= src_t_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      joy_q        <= joy_d;
      trig_q       <= trig_d;
      grant_any_q  <= grant_any_d;
      last_grant_q <= last_grant_d;
      rr_q         <= rr_d;
      clr_pend_q   <= clr_pend_d;
      join_q       <= join_d;
      overrun_q    <= overrun_d;
    end
  end

  assign player_key_o   = key_q;
  assign player_joy_o   = joy_q;
  assign player_trig_o  = trig_q;
  assign player_bound_o = bound_q;
  assign player_src_o   = src_q;
  assign join_pulse_o   = join_q;
  assign overrun_o      = overrun_q;

endmodule
